// File: rtl/amiga_clkgen.sv
// Chipset/CPU clock-enable generator for the 28 MHz domain: 7 MHz enables, c1/c3,
// colour clock, E-clock and a CPU enable with turbo rates, plus a 7 MHz-aligned pause.
module amiga_clkgen #(
    parameter int ECLK_DIV  = 10,
    parameter int ECLK_HIGH = 4
) (
    input  logic                clk_28,
    input  logic                reset_n,
    input  logic [1:0]          cpu_speed,
    input  logic                pause_req,
    output logic                pause_ack,
    output logic [1:0]          phase,
    output logic                clk7_en,
    output logic                clk7n_en,
    output logic                cpu_en,
    output logic                c1,
    output logic                c3,
    output logic                cck,
    output logic                cck_en,
    output logic                eclk,
    output logic                eclk_fall_en,
    output logic [ECLK_DIV-1:0] eclk_phase
);

    // state     | meaning
    // ST_RUN    | enables generated normally
    // ST_PAUSED | chipset and CPU enables held low, colour/E-clock frozen
    typedef enum logic {ST_RUN, ST_PAUSED} state_t;

    localparam int EW = (ECLK_DIV > 2) ? $clog2(ECLK_DIV) : 1;
    localparam logic [EW-1:0] ECNT_LAST = EW'(ECLK_DIV - 1);
    localparam logic [EW-1:0] ECNT_HIGH = EW'(ECLK_DIV - ECLK_HIGH);

    if (ECLK_DIV < 2 || ECLK_DIV > 16) begin : g_bad_div
        $error("amiga_clkgen: ECLK_DIV=%0d outside 2..16", ECLK_DIV);
    end
    if (ECLK_HIGH < 1 || ECLK_HIGH > ECLK_DIV - 1) begin : g_bad_high
        $error("amiga_clkgen: ECLK_HIGH=%0d outside 1..ECLK_DIV-1", ECLK_HIGH);
    end

    state_t              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [1:0]          spd_q, spd_d;
    logic [EW-1:0]       ecnt_q, ecnt_d;
    logic                clk7_en_q, clk7_en_d;
    logic                clk7n_en_q, clk7n_en_d;
    logic                cpu_en_q, cpu_en_d;
    logic                c1_q, c1_d;
    logic                c3_q, c3_d;
    logic                cck_q, cck_d;
    logic                cck_en_q, cck_en_d;
    logic                eclk_q, eclk_d;
    logic                eclk_fall_q, eclk_fall_d;
    logic [ECLK_DIV-1:0] eclk_phase_q, eclk_phase_d;
    logic                run_d;
    logic                step_d;

    always_comb begin
        cnt_d   = cnt_q + 2'd1;
        state_d = state_q;
        spd_d   = spd_q;
        // Pause and speed only change on the 7 MHz boundary; enables at this edge see the new values.
        if (cnt_q == 2'd3) begin
            state_d = pause_req ? ST_PAUSED : ST_RUN;
            spd_d   = cpu_speed;
        end
        run_d = (state_d == ST_RUN);

        clk7_en_d  = run_d && (cnt_q == 2'd0);
        clk7n_en_d = run_d && (cnt_q == 2'd2);
        case (spd_d)
            2'b01:   cpu_en_d = run_d && ((cnt_q == 2'd0) || (cnt_q == 2'd2));
            2'b10:   cpu_en_d = run_d;
            default: cpu_en_d = run_d && (cnt_q == 2'd0);
        endcase

        c3_d = cnt_q[1];
        c1_d = ~c3_q;

        step_d   = run_d && (cnt_q == 2'd1);
        cck_d    = step_d ? ~cck_q : cck_q;
        cck_en_d = step_d;

        ecnt_d      = ecnt_q;
        eclk_fall_d = 1'b0;
        if (step_d) begin
            if (ecnt_q == ECNT_LAST) begin
                ecnt_d      = '0;
                eclk_fall_d = 1'b1;
            end else begin
                ecnt_d = ecnt_q + 1'b1;
            end
        end
        eclk_d       = (ecnt_d >= ECNT_HIGH);
        eclk_phase_d = ECLK_DIV'(1) << ecnt_d;
    end

    always_ff @(posedge clk_28 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_RUN;
            cnt_q        <= 2'b10;
            spd_q        <= 2'b00;
            ecnt_q       <= '0;
            clk7_en_q    <= 1'b0;
            clk7n_en_q   <= 1'b0;
            cpu_en_q     <= 1'b0;
            c1_q         <= 1'b1;
            c3_q         <= 1'b0;
            cck_q        <= 1'b1;
            cck_en_q     <= 1'b0;
            eclk_q       <= 1'b0;
            eclk_fall_q  <= 1'b0;
            eclk_phase_q <= ECLK_DIV'(1);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            spd_q        <= spd_d;
            ecnt_q       <= ecnt_d;
            clk7_en_q    <= clk7_en_d;
            clk7n_en_q   <= clk7n_en_d;
            cpu_en_q     <= cpu_en_d;
            c1_q         <= c1_d;
            c3_q         <= c3_d;
            cck_q        <= cck_d;
            cck_en_q     <= cck_en_d;
            eclk_q       <= eclk_d;
            eclk_fall_q  <= eclk_fall_d;
            eclk_phase_q <= eclk_phase_d;
        end
    end

    assign pause_ack    = (state_q == ST_PAUSED);
    assign phase        = cnt_q;
    assign clk7_en      = clk7_en_q;
    assign clk7n_en     = clk7n_en_q;
    assign cpu_en       = cpu_en_q;
    assign c1           = c1_q;
    assign c3           = c3_q;
    assign cck          = cck_q;
    assign cck_en       = cck_en_q;
    assign eclk         = eclk_q;
    assign eclk_fall_en = eclk_fall_q;
    assign eclk_phase   = eclk_phase_q;

endmodule

// File: tb/tb_amiga_clkgen.sv
// Bench for amiga_clkgen: default and 6/2 E-clock instances checked each cycle against a
// cycle-count model, plus hand-derived counts for the directed scenarios.
module tb_amiga_clkgen;

    logic       clk_28 = 1'b0;
    logic       reset_n;
    logic [1:0] cpu_speed;
    logic       pause_req;

    logic       ack_a, ack_b, clk7_a, clk7_b, clk7n_a, clk7n_b, cpu_a, cpu_b;
    logic       c1_a, c1_b, c3_a, c3_b, cck_a, cck_b, ccken_a, ccken_b;
    logic       eclk_a, eclk_b, fall_a, fall_b;
    logic [1:0] phase_a, phase_b;
    logic [9:0] eph_a;
    logic [5:0] eph_b;

    amiga_clkgen u_a (
        .clk_28(clk_28), .reset_n(reset_n), .cpu_speed(cpu_speed), .pause_req(pause_req),
        .pause_ack(ack_a), .phase(phase_a), .clk7_en(clk7_a), .clk7n_en(clk7n_a),
        .cpu_en(cpu_a), .c1(c1_a), .c3(c3_a), .cck(cck_a), .cck_en(ccken_a),
        .eclk(eclk_a), .eclk_fall_en(fall_a), .eclk_phase(eph_a)
    );

    amiga_clkgen #(.ECLK_DIV(6), .ECLK_HIGH(2)) u_b (
        .clk_28(clk_28), .reset_n(reset_n), .cpu_speed(cpu_speed), .pause_req(pause_req),
        .pause_ack(ack_b), .phase(phase_b), .clk7_en(clk7_b), .clk7n_en(clk7n_b),
        .cpu_en(cpu_b), .c1(c1_b), .c3(c3_b), .cck(cck_b), .cck_en(ccken_b),
        .eclk(eclk_b), .eclk_fall_en(fall_b), .eclk_phase(eph_b)
    );

    initial forever #5 clk_28 = ~clk_28;

    int total = 0;
    int bad   = 0;

    // model state: absolute quantities, one cycle = one clk_28 edge
    int m_cnt, m_spd, m_paused, m_c1, m_c3, m_cck, m_cck_en, m_clk7, m_clk7n, m_cpu;
    int m_ecnt[2];
    int m_fall[2];
    int div_k[2] = '{10, 6};
    int hi_k[2]  = '{4, 2};

    int n_clk7, n_clk7n, n_cpu, n_ccken, n_ack, n_fall_a, n_fall_b, n_hi_a, n_hi_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 2; m_spd = 0; m_paused = 0; m_c1 = 1; m_c3 = 0; m_cck = 1;
        m_cck_en = 0; m_clk7 = 0; m_clk7n = 0; m_cpu = 0;
        for (int k = 0; k < 2; k++) begin
            m_ecnt[k] = 0;
            m_fall[k] = 0;
        end
    endtask

    task automatic model_step();
        int c, run, per7;
        if (!reset_n) begin
            model_reset();
        end else begin
            c = m_cnt;
            if (c == 3) begin
                m_paused = int'(pause_req);
                m_spd    = int'(cpu_speed);
            end
            run     = (m_paused == 0) ? 1 : 0;
            m_clk7  = (run == 1 && c == 0) ? 1 : 0;
            m_clk7n = (run == 1 && c == 2) ? 1 : 0;
            // CPU pulses per 7 MHz period: 1, 2 or 4, evenly spaced from phase 0
            per7  = (m_spd == 1) ? 2 : (m_spd == 2) ? 4 : 1;
            m_cpu = (run == 1 && (c % (4 / per7)) == 0) ? 1 : 0;
            m_c1  = 1 - m_c3;
            m_c3  = c / 2;
            m_cck_en = (run == 1 && c == 1) ? 1 : 0;
            if (m_cck_en == 1) m_cck = 1 - m_cck;
            for (int k = 0; k < 2; k++) begin
                m_fall[k] = 0;
                if (m_cck_en == 1) begin
                    m_ecnt[k] = (m_ecnt[k] + 1) % div_k[k];
                    m_fall[k] = (m_ecnt[k] == 0) ? 1 : 0;
                end
            end
            m_cnt = (c + 1) % 4;
        end
    endtask

    task automatic compare_all();
        check("phase_a", 32'(phase_a), 32'(m_cnt));
        check("phase_b", 32'(phase_b), 32'(m_cnt));
        check("ack_a", 32'(ack_a), 32'(m_paused));
        check("ack_b", 32'(ack_b), 32'(m_paused));
        check("clk7_a", 32'(clk7_a), 32'(m_clk7));
        check("clk7_b", 32'(clk7_b), 32'(m_clk7));
        check("clk7n_a", 32'(clk7n_a), 32'(m_clk7n));
        check("clk7n_b", 32'(clk7n_b), 32'(m_clk7n));
        check("cpu_a", 32'(cpu_a), 32'(m_cpu));
        check("cpu_b", 32'(cpu_b), 32'(m_cpu));
        check("c1_a", 32'(c1_a), 32'(m_c1));
        check("c1_b", 32'(c1_b), 32'(m_c1));
        check("c3_a", 32'(c3_a), 32'(m_c3));
        check("c3_b", 32'(c3_b), 32'(m_c3));
        check("cck_a", 32'(cck_a), 32'(m_cck));
        check("cck_b", 32'(cck_b), 32'(m_cck));
        check("ccken_a", 32'(ccken_a), 32'(m_cck_en));
        check("ccken_b", 32'(ccken_b), 32'(m_cck_en));
        check("eclk_a", 32'(eclk_a), (m_ecnt[0] >= div_k[0] - hi_k[0]) ? 32'd1 : 32'd0);
        check("eclk_b", 32'(eclk_b), (m_ecnt[1] >= div_k[1] - hi_k[1]) ? 32'd1 : 32'd0);
        check("fall_a", 32'(fall_a), 32'(m_fall[0]));
        check("fall_b", 32'(fall_b), 32'(m_fall[1]));
        check("eph_a", 32'(eph_a), 32'd1 << m_ecnt[0]);
        check("eph_b", 32'(eph_b), 32'd1 << m_ecnt[1]);
    endtask

    // one clk_28 cycle: model advances on the edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge clk_28);
        model_step();
        @(negedge clk_28);
        compare_all();
        n_clk7   += int'(clk7_a);
        n_clk7n  += int'(clk7n_a);
        n_cpu    += int'(cpu_a);
        n_ccken  += int'(ccken_a);
        n_ack    += int'(ack_a);
        n_fall_a += int'(fall_a);
        n_fall_b += int'(fall_b);
        n_hi_a   += int'(eclk_a);
        n_hi_b   += int'(eclk_b);
    endtask

    task automatic clear_counts();
        n_clk7 = 0; n_clk7n = 0; n_cpu = 0; n_ccken = 0; n_ack = 0;
        n_fall_a = 0; n_fall_b = 0; n_hi_a = 0; n_hi_b = 0;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 8 && int'(phase_a) != p; i++) tick();
        check("wait_phase", 32'(phase_a), 32'(p));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_clk7"}, 32'(clk7_a), 32'd0);
        check({tag, "_clk7n"}, 32'(clk7n_a), 32'd0);
        check({tag, "_cpu"}, 32'(cpu_a), 32'd0);
        check({tag, "_cck"}, 32'(cck_a), 32'd1);
        check({tag, "_c1"}, 32'(c1_a), 32'd1);
        check({tag, "_c3"}, 32'(c3_a), 32'd0);
        check({tag, "_eclk"}, 32'(eclk_a), 32'd0);
        check({tag, "_eph_a"}, 32'(eph_a), 32'd1);
        check({tag, "_eph_b"}, 32'(eph_b), 32'd1);
        check({tag, "_ack"}, 32'(ack_a), 32'd0);
        check({tag, "_phase"}, 32'(phase_a), 32'd2);
    endtask

    // 80 cycles from reset release with default inputs, hand-derived counts
    task automatic run_default_80(input string tag);
        int first7, first7n;
        first7 = -1;
        first7n = -1;
        clear_counts();
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (clk7_a && first7 < 0) first7 = i;
            if (clk7n_a && first7n < 0) first7n = i;
        end
        check({tag, "_first_clk7"}, 32'(first7), 32'd3);
        check({tag, "_first_clk7n"}, 32'(first7n), 32'd1);
        check({tag, "_n_clk7"}, 32'(n_clk7), 32'd20);
        check({tag, "_n_cpu"}, 32'(n_cpu), 32'd20);
        check({tag, "_n_ccken"}, 32'(n_ccken), 32'd20);
        check({tag, "_n_fall_a"}, 32'(n_fall_a), 32'd2);
        check({tag, "_n_hi_a"}, 32'(n_hi_a), 32'd32);
        check({tag, "_n_fall_b"}, 32'(n_fall_b), 32'd3);
        check({tag, "_n_hi_b"}, 32'(n_hi_b), 32'd24);
        check({tag, "_eph_a_end"}, 32'(eph_a), 32'd1);
        check({tag, "_eph_b_end"}, 32'(eph_b), 32'd4);
    endtask

    initial begin
        int first, lim;
        reset_n   = 1'b0;
        cpu_speed = 2'b00;
        pause_req = 1'b0;
        model_reset();
        clear_counts();
        repeat (3) tick();
        check_reset_values("rst");
        reset_n = 1'b1;
        run_default_80("dflt");

        // speed 01 selected at phase 1: latches on the next phase-3 edge
        wait_phase(1);
        cpu_speed = 2'b01;
        clear_counts();
        repeat (16) tick();
        check("spd01_n_cpu", 32'(n_cpu), 32'd7);
        wait_phase(1);
        cpu_speed = 2'b10;
        clear_counts();
        repeat (16) tick();
        check("spd10_n_cpu", 32'(n_cpu), 32'd15);
        wait_phase(1);
        cpu_speed = 2'b00;
        repeat (8) tick();

        // held pause: ack after the phase-3 edge, everything gated for the duration
        wait_phase(0);
        pause_req = 1'b1;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (ack_a && first < 0) first = i;
        end
        check("pause_ack_latency", 32'(first), 32'd4);
        clear_counts();
        repeat (40) tick();
        check("paused_enables", 32'(n_clk7 + n_clk7n + n_cpu + n_ccken + n_fall_a), 32'd0);
        check("paused_ack_cycles", 32'(n_ack), 32'd40);
        wait_phase(0);
        pause_req = 1'b0;
        first = -1;
        lim = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (!ack_a && first < 0) first = i;
            if (clk7_a && lim < 0) lim = i;
        end
        check("release_latency", 32'(first), 32'd4);
        check("release_first_clk7", 32'(lim), 32'd5);

        // short pulse that misses the phase-3 edge
        wait_phase(0);
        clear_counts();
        pause_req = 1'b1;
        repeat (2) tick();
        pause_req = 1'b0;
        repeat (8) tick();
        check("short_pulse_ack", 32'(n_ack), 32'd0);
        check("short_pulse_clk7", 32'(n_clk7), 32'd3);

        // randomized speed and pause traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) cpu_speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) pause_req = ~pause_req;
            tick();
        end
        pause_req = 1'b0;
        cpu_speed = 2'b00;
        repeat (8) tick();

        // reset asserted mid-cycle while paused with eclk high
        for (int i = 0; i < 200 && !eclk_a; i++) tick();
        check("eclk_seen_high", 32'(eclk_a), 32'd1);
        pause_req = 1'b1;
        for (int i = 0; i < 8 && !ack_a; i++) tick();
        check("paused_before_reset", 32'(ack_a), 32'd1);
        check("eclk_high_before_reset", 32'(eclk_a), 32'd1);
        tick();
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        check_reset_values("async_rst");
        pause_req = 1'b0;
        @(negedge clk_28);
        repeat (2) tick();
        reset_n = 1'b1;
        run_default_80("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
